// File: rtl/game_pkg.sv
// Shared types and constants for the turn controller and its wind generator.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AIM,
    ST_CHARGE,
    ST_THROW,
    ST_RESOLVE,
    ST_OVER
  } turn_state_t;

  localparam logic PLAYER_DOG = 1'b0;
  localparam logic PLAYER_CAT = 1'b1;

  localparam logic [6:0] WIND_NEUTRAL = 7'd50;

  // Folds a raw 1..127 LFSR value into the 1..100 wind range.
  function automatic logic [6:0] wind_fold(input logic [6:0] raw);
    return (raw > 7'd100) ? raw - 7'd27 : raw;
  endfunction

endpackage

// File: rtl/wind_lfsr.sv
// Free-running 7-bit LFSR (x^7+x^6+1); wind output captures the folded value on load.
module wind_lfsr
  import game_pkg::*;
#(
  parameter logic [6:0] LFSR_SEED = 7'h5A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  output logic [6:0] wind
);

  logic [6:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
      wind <= WIND_NEUTRAL;
    end else begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      if (load) wind <= wind_fold(lfsr);
    end
  end

endmodule

// File: rtl/throw_turn_ctl.sv
// Turn controller: charges throw force from the mouse, runs the active thrower, applies damage.
//   state      | meaning
//   ST_IDLE    | waiting for start
//   ST_AIM     | waiting for a fresh mouse press
//   ST_CHARGE  | button held, force ramps up
//   ST_THROW   | active thrower enabled, collecting hits until done
//   ST_RESOLVE | one cycle: apply damage, pick next turn or end game
//   ST_OVER    | game finished, waiting for start
module throw_turn_ctl
  import game_pkg::*;
#(
  parameter int         HP_MAX       = 100,
  parameter int         DAMAGE       = 20,
  parameter int         CHARGE_TICKS = 650000,
  parameter logic [6:0] LFSR_SEED    = 7'h5A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mouse_left,
  input  logic       throw_done_dog,
  input  logic       throw_done_cat,
  input  logic       hit_dog,
  input  logic       hit_cat,
  output logic       enable_dog,
  output logic       enable_cat,
  output logic [9:0] throw_force,
  output logic [6:0] wind_force,
  output logic [7:0] hp_dog,
  output logic [7:0] hp_cat,
  output logic       turn,
  output logic       game_over,
  output logic       winner
);

  localparam int            CW       = (CHARGE_TICKS > 1) ? $clog2(CHARGE_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CHARGE_TICKS - 1);
  localparam logic [7:0]    HP_INIT  = 8'(HP_MAX);
  localparam logic [7:0]    DMG      = 8'(DAMAGE);

  turn_state_t   state, state_d;
  logic          mouse_prev, mouse_rise;
  logic [CW-1:0] cnt, cnt_d;
  logic [9:0]    force_d;
  logic [7:0]    hp_dog_d, hp_cat_d, opp_hp, opp_after;
  logic          turn_d, winner_d, game_over_d;
  logic          hit_seen, hit_seen_d, done_act, hit_act;
  logic          en_dog_d, en_cat_d, wind_load;

  assign mouse_rise = mouse_left & ~mouse_prev;
  assign done_act   = (turn == PLAYER_CAT) ? throw_done_cat : throw_done_dog;
  assign hit_act    = (turn == PLAYER_CAT) ? hit_cat : hit_dog;
  assign opp_hp     = (turn == PLAYER_CAT) ? hp_dog : hp_cat;
  assign opp_after  = !hit_seen ? opp_hp : ((opp_hp > DMG) ? opp_hp - DMG : 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE, ST_OVER: if (start)       state_d = ST_AIM;
      ST_AIM:           if (mouse_rise)  state_d = ST_CHARGE;
      ST_CHARGE:        if (!mouse_left) state_d = ST_THROW;
      ST_THROW:         if (done_act)    state_d = ST_RESOLVE;
      ST_RESOLVE:       state_d = (opp_after == 8'd0) ? ST_OVER : ST_AIM;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt;
    force_d    = throw_force;
    hp_dog_d   = hp_dog;
    hp_cat_d   = hp_cat;
    turn_d     = turn;
    winner_d   = winner;
    hit_seen_d = hit_seen;
    wind_load  = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          hp_dog_d   = HP_INIT;
          hp_cat_d   = HP_INIT;
          turn_d     = PLAYER_DOG;
          hit_seen_d = 1'b0;
          wind_load  = 1'b1;
        end
      end
      ST_AIM: begin
        if (mouse_rise) begin
          cnt_d   = '0;
          force_d = '0;
        end
      end
      ST_CHARGE: begin
        if (mouse_left) begin
          if (cnt == CNT_LAST) begin
            cnt_d = '0;
            if (throw_force != 10'h3FF) force_d = throw_force + 10'd1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      ST_THROW: hit_seen_d = hit_seen | hit_act;
      ST_RESOLVE: begin
        hit_seen_d = 1'b0;
        if (turn == PLAYER_CAT) hp_dog_d = opp_after;
        else                    hp_cat_d = opp_after;
        if (opp_after == 8'd0) begin
          winner_d = turn;
        end else begin
          turn_d    = ~turn;
          wind_load = 1'b1;
        end
      end
      default: ;
    endcase
    // Enables follow the next state so they rise on the first ST_THROW cycle.
    game_over_d = (state_d == ST_OVER);
    en_dog_d    = (state_d == ST_THROW) && (turn_d == PLAYER_DOG);
    en_cat_d    = (state_d == ST_THROW) && (turn_d == PLAYER_CAT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mouse_prev  <= 1'b0;
      cnt         <= '0;
      throw_force <= '0;
      hp_dog      <= HP_INIT;
      hp_cat      <= HP_INIT;
      turn        <= PLAYER_DOG;
      winner      <= 1'b0;
      game_over   <= 1'b0;
      hit_seen    <= 1'b0;
      enable_dog  <= 1'b0;
      enable_cat  <= 1'b0;
    end else begin
      mouse_prev  <= mouse_left;
      cnt         <= cnt_d;
      throw_force <= force_d;
      hp_dog      <= hp_dog_d;
      hp_cat      <= hp_cat_d;
      turn        <= turn_d;
      winner      <= winner_d;
      game_over   <= game_over_d;
      hit_seen    <= hit_seen_d;
      enable_dog  <= en_dog_d;
      enable_cat  <= en_cat_d;
    end
  end

  wind_lfsr #(.LFSR_SEED(LFSR_SEED)) u_wind (
    .clk  (clk),
    .rst_n(rst_n),
    .load (wind_load),
    .wind (wind_force)
  );

endmodule

// File: tb/tb_throw_turn_ctl.sv
// Bench for throw_turn_ctl: game-rule model checked every cycle plus directed literal checks.
module tb_throw_turn_ctl;

  localparam int TICKS = 4;
  localparam int HPM   = 100;
  localparam int DMG   = 20;

  localparam int P_IDLE = 0, P_AIM = 1, P_CHARGE = 2, P_THROW = 3, P_RESOLVE = 4, P_OVER = 5;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, mouse_left = 1'b0;
  logic       throw_done_dog = 1'b0, throw_done_cat = 1'b0;
  logic       hit_dog = 1'b0, hit_cat = 1'b0;
  logic       enable_dog, enable_cat, turn, game_over, winner;
  logic [9:0] throw_force;
  logic [6:0] wind_force;
  logic [7:0] hp_dog, hp_cat;

  int total = 0;
  int bad   = 0;

  throw_turn_ctl #(.HP_MAX(HPM), .DAMAGE(DMG), .CHARGE_TICKS(TICKS), .LFSR_SEED(7'h5A)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mouse_left(mouse_left),
    .throw_done_dog(throw_done_dog), .throw_done_cat(throw_done_cat),
    .hit_dog(hit_dog), .hit_cat(hit_cat),
    .enable_dog(enable_dog), .enable_cat(enable_cat),
    .throw_force(throw_force), .wind_force(wind_force),
    .hp_dog(hp_dog), .hp_cat(hp_cat), .turn(turn),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Game-rule model: phase of play, HP array indexed by player, force from held-cycle count.
  int m_phase = P_IDLE;
  int m_hp[2] = '{HPM, HPM};
  int m_turn = 0, m_win = 0, m_force = 0, m_held = 0, m_wind = 50;
  int m_lfsr = 'h5A, m_seen = 0, m_mprev = 0;

  function automatic int fold(input int v);
    return (v > 100) ? v - 27 : v;
  endfunction

  function automatic int lfsr_step(input int v);
    int fb;
    fb = ((v >> 6) ^ (v >> 5)) & 1;
    return ((v << 1) & 127) | fb;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = P_IDLE; m_hp[0] = HPM; m_hp[1] = HPM; m_turn = 0; m_win = 0;
      m_force = 0; m_held = 0; m_wind = 50; m_lfsr = 'h5A; m_seen = 0; m_mprev = 0;
    end else begin
      case (m_phase)
        P_IDLE, P_OVER: if (start) begin
          m_hp[0] = HPM; m_hp[1] = HPM; m_turn = 0; m_seen = 0;
          m_wind = fold(m_lfsr); m_phase = P_AIM;
        end
        P_AIM: if (mouse_left && !m_mprev) begin
          m_phase = P_CHARGE; m_force = 0; m_held = 0;
        end
        P_CHARGE: if (mouse_left) begin
          m_held++;
          m_force = (m_held / TICKS > 1023) ? 1023 : m_held / TICKS;
        end else m_phase = P_THROW;
        P_THROW: begin
          if (m_turn == 1 ? hit_cat : hit_dog) m_seen = 1;
          if (m_turn == 1 ? throw_done_cat : throw_done_dog) m_phase = P_RESOLVE;
        end
        P_RESOLVE: begin
          if (m_seen) m_hp[1-m_turn] = (m_hp[1-m_turn] > DMG) ? m_hp[1-m_turn] - DMG : 0;
          m_seen = 0;
          if (m_hp[1-m_turn] == 0) begin
            m_phase = P_OVER; m_win = m_turn;
          end else begin
            m_turn = 1 - m_turn; m_wind = fold(m_lfsr); m_phase = P_AIM;
          end
        end
        default: ;
      endcase
      m_mprev = mouse_left;
      m_lfsr  = lfsr_step(m_lfsr);
    end
  end

  initial forever begin
    logic [45:0] got, exp;
    @(negedge clk);
    if (rst_n) begin
      got = {enable_dog, enable_cat, throw_force, wind_force, hp_dog, hp_cat, turn, game_over, winner};
      exp = {1'(m_phase == P_THROW && m_turn == 0), 1'(m_phase == P_THROW && m_turn == 1),
             10'(m_force), 7'(m_wind), 8'(m_hp[0]), 8'(m_hp[1]), 1'(m_turn),
             1'(m_phase == P_OVER), 1'(m_win)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL model_cmp t=%0t got=%h expected=%h (en_d en_c force wind hp_d hp_c turn over win)",
                 $time, got, exp);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic press(input int n);
    mouse_left = 1'b1; cyc(n); mouse_left = 1'b0; cyc(1);
  endtask

  // Called in ST_THROW: optional active-side hit in the same cycle as done, then resolve.
  task automatic finish_throw(input bit hit);
    if (m_turn == 1) begin hit_cat = hit; throw_done_cat = 1'b1; end
    else             begin hit_dog = hit; throw_done_dog = 1'b1; end
    cyc(1);
    hit_dog = 1'b0; hit_cat = 1'b0; throw_done_dog = 1'b0; throw_done_cat = 1'b0;
    cyc(1);
  endtask

  task automatic random_turn();
    int nd;
    mouse_left = 1'b0;
    start = ($urandom_range(0, 3) == 0);
    cyc($urandom_range(1, 3));
    start = 1'b0;
    press($urandom_range(1, 30));
    nd = $urandom_range(1, 5);
    for (int i = 0; i < nd; i++) begin
      hit_dog    = ($urandom_range(0, 9) < 3);
      hit_cat    = ($urandom_range(0, 9) < 3);
      mouse_left = $urandom_range(0, 1);
      if (m_turn == 1) begin
        throw_done_cat = (i == nd - 1); throw_done_dog = $urandom_range(0, 1);
      end else begin
        throw_done_dog = (i == nd - 1); throw_done_cat = $urandom_range(0, 1);
      end
      cyc(1);
    end
    hit_dog = 1'b0; hit_cat = 1'b0;
    mouse_left = $urandom_range(0, 1);
    if ($urandom_range(0, 1) == 0) begin throw_done_dog = 1'b0; throw_done_cat = 1'b0; end
    cyc(1);
    throw_done_dog = 1'b0; throw_done_cat = 1'b0;
    cyc(1);
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_hp_dog", hp_dog, 100);
    chk("rst_hp_cat", hp_cat, 100);
    chk("rst_wind", wind_force, 50);
    chk("rst_enables", {enable_dog, enable_cat}, 0);
    chk("rst_turn", turn, 0);

    pulse_start();
    chk("start_hp_cat", hp_cat, 100);
    chk("start_wind_in_range", int'(wind_force >= 1 && wind_force <= 100), 1);

    press(41);
    chk("dog_force_10", throw_force, 10);
    chk("dog_enable_on", enable_dog, 1);
    chk("dog_cat_enable_off", enable_cat, 0);
    hit_dog = 1'b1; cyc(1); hit_dog = 1'b0; cyc(1);
    hit_dog = 1'b1; cyc(1); hit_dog = 1'b0;
    throw_done_dog = 1'b1; cyc(1); throw_done_dog = 1'b0;
    chk("dog_enable_drop", enable_dog, 0);
    cyc(1);
    chk("two_hits_hp_cat", hp_cat, 80);
    chk("turn_to_cat", turn, 1);

    pulse_start();
    press(9);
    chk("cat_enable_on", enable_cat, 1);
    chk("cat_dog_enable_off", enable_dog, 0);
    hit_dog = 1'b1; cyc(1); hit_dog = 1'b0;
    finish_throw(1'b0);
    chk("cat_miss_hp_dog", hp_dog, 100);
    chk("cat_miss_hp_cat", hp_cat, 80);
    chk("turn_to_dog", turn, 0);

    press(5001);
    chk("force_saturate", throw_force, 1023);
    finish_throw(1'b0);
    press(3);
    finish_throw(1'b0);

    for (int k = 0; k < 4; k++) begin
      press(6);
      finish_throw(1'b1);
      if (k < 3) begin
        press(2);
        finish_throw(1'b0);
      end
    end
    chk("over_hp_cat", hp_cat, 0);
    chk("over_flag", game_over, 1);
    chk("over_winner_dog", winner, 0);
    press(5);
    chk("over_holds_hp_dog", hp_dog, 100);
    chk("over_no_enable", {enable_dog, enable_cat}, 0);

    pulse_start();
    chk("restart_hp_dog", hp_dog, 100);
    chk("restart_hp_cat", hp_cat, 100);
    chk("restart_turn", turn, 0);
    chk("restart_over_clear", game_over, 0);

    for (int g = 0; g < 3; g++) begin
      for (int t = 0; t < 60 && m_phase != P_OVER; t++) random_turn();
      chk("random_game_ended", int'(m_phase == P_OVER), 1);
      mouse_left = 1'b0;
      cyc(2);
      pulse_start();
    end

    press(10);
    chk("pre_reset_enable", enable_dog, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_enable_drop", enable_dog, 0);
    chk("async_force", throw_force, 0);
    chk("async_wind", wind_force, 50);
    chk("async_hp_cat", hp_cat, 100);
    chk("async_over", game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    press(5);
    chk("idle_after_reset_no_enable", enable_dog, 0);
    chk("idle_after_reset_force", throw_force, 0);
    pulse_start();
    press(8);
    chk("post_reset_throw_force", throw_force, 1);
    chk("post_reset_enable", enable_dog, 1);
    finish_throw(1'b1);
    chk("post_reset_hit", hp_cat, 80);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
